// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, state encoding and baud table for the UART receive path
package uart_pkg;

    localparam int TICKS_PER_BIT = 16;
    localparam int DRAIN_TICKS   = TICKS_PER_BIT;
    localparam int RX_ENTRY_W    = 10;
    localparam int DIV_W         = 14;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_IDLE  = 2'd1,
        ST_FRAME = 2'd2,
        ST_DRAIN = 2'd3
    } rx_state_e;

    // System clocks per 16x sample tick at 50 MHz, indexed by baud_select.
    function automatic logic [DIV_W-1:0] baud_div(input logic [2:0] sel);
        logic [DIV_W-1:0] div;
        case (sel)
            3'd0:    div = 14'd10417;
            3'd1:    div = 14'd2604;
            3'd2:    div = 14'd651;
            3'd3:    div = 14'd326;
            3'd4:    div = 14'd163;
            3'd5:    div = 14'd81;
            3'd6:    div = 14'd54;
            default: div = 14'd27;
        endcase
        return div;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - synchronous first-word-fall-through FIFO for received frame entries
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = RX_ENTRY_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_en;
    logic             rd_en;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign rd_en    = pop && !empty;
    // A full FIFO still accepts a write when the head leaves in the same clock.
    assign wr_en    = push && (!full || rd_en);
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(wr_en);
        rd_ptr_d = rd_ptr_q + AW'(rd_en);
        count_d  = count_q + CW'(wr_en) - CW'(rd_en);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - sample-tick divider, frame-safe receiver enable and status capture FIFO
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter bit DROP_ERR      = 1'b0,
    parameter int TIMEOUT_TICKS = 192
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    input  logic       rx_enable,
    input  logic       RxD,
    output logic       Rx_sample,
    output logic       Rx_EN,
    input  logic [7:0] Rx_DATA,
    input  logic       Rx_VALID,
    input  logic       Rx_FERROR,
    input  logic       Rx_PERROR,
    output logic       rd_valid,
    input  logic       rd_ready,
    output logic [7:0] rd_data,
    output logic       rd_ferror,
    output logic       rd_perror,
    output logic       busy,
    output logic       overflow,
    output logic [7:0] err_count,
    input  logic       clear_status
);

    localparam int TICK_MAX = (TIMEOUT_TICKS > DRAIN_TICKS) ? TIMEOUT_TICKS : DRAIN_TICKS;
    localparam int TW       = $clog2(TICK_MAX);

    rx_state_e             state_q, state_d;
    logic [2:0]            div_sel_q, div_sel_d;
    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic [TW-1:0]         tick_q, tick_d;
    logic                  rxd_meta_q, rxd_meta_d;
    logic                  rxd_s_q, rxd_s_d;
    logic                  rxd_prev_q, rxd_prev_d;
    logic                  stat_prev_q, stat_prev_d;
    logic                  rx_en_q, rx_en_d;
    logic                  busy_q, busy_d;
    logic                  overflow_q, overflow_d;
    logic [7:0]            err_count_q, err_count_d;

    logic [DIV_W-1:0]      div;
    logic                  sample;
    logic                  status;
    logic                  stat_event;
    logic                  start_edge;
    logic                  frame_err;
    logic                  push_evt;
    logic                  push_req;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [RX_ENTRY_W-1:0] fifo_head;

    assign div        = baud_div(div_sel_q);
    assign sample     = (div_cnt_q == div - DIV_W'(1));
    assign status     = Rx_VALID | Rx_FERROR | Rx_PERROR;
    assign stat_event = status && !stat_prev_q;
    assign start_edge = rxd_prev_q && !rxd_s_q;
    assign frame_err  = Rx_FERROR | Rx_PERROR;
    assign pop        = !fifo_empty && rd_ready;

    always_comb begin
        state_d     = state_q;
        div_sel_d   = div_sel_q;
        div_cnt_d   = div_cnt_q;
        tick_d      = tick_q;
        rxd_meta_d  = RxD;
        rxd_s_d     = rxd_meta_q;
        rxd_prev_d  = rxd_s_q;
        stat_prev_d = status;
        overflow_d  = overflow_q;
        err_count_d = err_count_q;
        push_evt    = 1'b0;
        push_req    = 1'b0;

        // The rate is frozen once a frame is under way so its bit timing never shifts.
        if (state_q == ST_OFF || state_q == ST_IDLE) begin
            div_sel_d = baud_select;
        end
        if (div_sel_d != div_sel_q || sample) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end

        case (state_q)
            ST_OFF: begin
                if (rx_enable) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (start_edge) begin
                    state_d = ST_FRAME;
                    tick_d  = '0;
                end else if (!rx_enable) begin
                    state_d = ST_OFF;
                end
            end
            ST_FRAME: begin
                if (stat_event) begin
                    push_evt = 1'b1;
                    state_d  = ST_DRAIN;
                    tick_d   = '0;
                end else if (sample) begin
                    if (tick_q == TW'(TIMEOUT_TICKS - 1)) begin
                        state_d = ST_DRAIN;
                        tick_d  = '0;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (sample) begin
                    if (tick_q == TW'(DRAIN_TICKS - 1)) begin
                        state_d = rx_enable ? ST_IDLE : ST_OFF;
                        tick_d  = '0;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            default: state_d = ST_OFF;
        endcase

        push_req = push_evt && !(DROP_ERR && frame_err);
        if (push_evt && frame_err && err_count_q != 8'hFF) begin
            err_count_d = err_count_q + 8'd1;
        end
        if (push_req && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end
        if (clear_status) begin
            overflow_d  = 1'b0;
            err_count_d = 8'd0;
        end

        rx_en_d = (state_d != ST_OFF);
        busy_d  = (state_d == ST_FRAME) || (state_d == ST_DRAIN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_OFF;
            div_sel_q   <= baud_select;
            div_cnt_q   <= '0;
            tick_q      <= '0;
            rxd_meta_q  <= 1'b0;
            rxd_s_q     <= 1'b0;
            rxd_prev_q  <= 1'b0;
            stat_prev_q <= 1'b0;
            rx_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            div_sel_q   <= div_sel_d;
            div_cnt_q   <= div_cnt_d;
            tick_q      <= tick_d;
            rxd_meta_q  <= rxd_meta_d;
            rxd_s_q     <= rxd_s_d;
            rxd_prev_q  <= rxd_prev_d;
            stat_prev_q <= stat_prev_d;
            rx_en_q     <= rx_en_d;
            busy_q      <= busy_d;
            overflow_q  <= overflow_d;
            err_count_q <= err_count_d;
        end
    end

    uart_rx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (RX_ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_req),
        .push_data ({Rx_FERROR, Rx_PERROR, Rx_DATA}),
        .full      (fifo_full),
        .pop       (pop),
        .pop_data  (fifo_head),
        .empty     (fifo_empty)
    );

    assign Rx_sample = sample;
    assign Rx_EN     = rx_en_q;
    assign busy      = busy_q;
    assign overflow  = overflow_q;
    assign err_count = err_count_q;
    assign rd_valid  = !fifo_empty;
    assign rd_data   = fifo_head[7:0];
    assign rd_perror = fifo_head[8];
    assign rd_ferror = fifo_head[9];

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - randomized bench for uart_rx_ctrl with DROP_ERR=0 and DROP_ERR=1 instances
module tb_uart_rx_ctrl;

    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            reset, rx_enable, RxD, Rx_VALID, Rx_FERROR, Rx_PERROR, clear_status;
    logic [2:0]      baud_select;
    logic [7:0]      Rx_DATA;
    logic [1:0]      rd_ready, Rx_sample, Rx_EN, rd_valid, rd_ferror, rd_perror, busy, overflow;
    logic [1:0][7:0] rd_data, err_count;

    int tests = 0, fails = 0, en_drops = 0, cycles = 0;

    // Reference: expected FIFO contents {ferr, perr, data} and status per instance.
    logic [9:0] mq [2][$];
    bit         exp_ovf [2];
    int         exp_err [2];

    always #5 clk = ~clk;

    uart_rx_ctrl #(.DEPTH(DEPTH), .DROP_ERR(1'b0), .TIMEOUT_TICKS(192)) dut0 (
        .clk(clk), .reset(reset), .baud_select(baud_select), .rx_enable(rx_enable), .RxD(RxD),
        .Rx_sample(Rx_sample[0]), .Rx_EN(Rx_EN[0]), .Rx_DATA(Rx_DATA), .Rx_VALID(Rx_VALID),
        .Rx_FERROR(Rx_FERROR), .Rx_PERROR(Rx_PERROR), .rd_valid(rd_valid[0]), .rd_ready(rd_ready[0]),
        .rd_data(rd_data[0]), .rd_ferror(rd_ferror[0]), .rd_perror(rd_perror[0]), .busy(busy[0]),
        .overflow(overflow[0]), .err_count(err_count[0]), .clear_status(clear_status)
    );

    uart_rx_ctrl #(.DEPTH(DEPTH), .DROP_ERR(1'b1), .TIMEOUT_TICKS(192)) dut1 (
        .clk(clk), .reset(reset), .baud_select(baud_select), .rx_enable(rx_enable), .RxD(RxD),
        .Rx_sample(Rx_sample[1]), .Rx_EN(Rx_EN[1]), .Rx_DATA(Rx_DATA), .Rx_VALID(Rx_VALID),
        .Rx_FERROR(Rx_FERROR), .Rx_PERROR(Rx_PERROR), .rd_valid(rd_valid[1]), .rd_ready(rd_ready[1]),
        .rd_data(rd_data[1]), .rd_ferror(rd_ferror[1]), .rd_perror(rd_perror[1]), .busy(busy[1]),
        .overflow(overflow[1]), .err_count(err_count[1]), .clear_status(clear_status)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cycles++;
        for (int d = 0; d < 2; d++) begin
            if (busy[d] && !Rx_EN[d]) en_drops++;
        end
    endtask

    task automatic wait_ticks(input int n);
        int cyc;
        for (int i = 0; i < n; i++) begin
            cyc = 0;
            while (!Rx_sample[0] && cyc < 1000) begin
                step();
                cyc++;
            end
            if (cyc >= 1000) begin
                check("tick_wait", Rx_sample[0], 1);
                return;
            end
            step();
        end
    endtask

    task automatic check_dut(input int d);
        logic [9:0] h;
        h = (mq[d].size() > 0) ? mq[d][0] : 10'd0;
        check($sformatf("rd_valid%0d", d), rd_valid[d], mq[d].size() > 0);
        check($sformatf("rd_data%0d", d), rd_data[d], h[7:0]);
        check($sformatf("rd_ferror%0d", d), rd_ferror[d], h[9]);
        check($sformatf("rd_perror%0d", d), rd_perror[d], h[8]);
        check($sformatf("overflow%0d", d), overflow[d], exp_ovf[d]);
        check($sformatf("err_count%0d", d), err_count[d], exp_err[d]);
    endtask

    task automatic check_reset();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_sample%0d", d), Rx_sample[d], 0);
            check($sformatf("rst_en%0d", d), Rx_EN[d], 0);
            check($sformatf("rst_busy%0d", d), busy[d], 0);
            check_dut(d);
        end
    endtask

    task automatic model_event(input int d, input logic [9:0] e, input bit pop, input bit clr);
        bit err;
        err = e[9] | e[8];
        if (pop && mq[d].size() > 0) void'(mq[d].pop_front());
        if (!(d == 1 && err)) begin
            if (mq[d].size() < DEPTH) mq[d].push_back(e);
            else exp_ovf[d] = 1'b1;
        end
        if (err && exp_err[d] < 255) exp_err[d]++;
        if (clr) begin
            exp_ovf[d] = 1'b0;
            exp_err[d] = 0;
        end
    endtask

    task automatic pop_all();
        int guard;
        for (int d = 0; d < 2; d++) begin
            guard = 0;
            while (mq[d].size() > 0 && guard < 20) begin
                check_dut(d);
                rd_ready[d] = 1'b1;
                step();
                rd_ready[d] = 1'b0;
                void'(mq[d].pop_front());
                guard++;
            end
            check_dut(d);
        end
    endtask

    task automatic do_frame(input logic [7:0] data, input logic fe, input logic pe, input int delay,
                            input int dis_at, input bit clr, input bit pop);
        int cyc, ticks, c0;
        c0 = 0;
        RxD = 1'b0;
        cyc = 0;
        while (!busy[0] && cyc < 10) begin
            step();
            cyc++;
        end
        check("frame_start0", busy[0], 1);
        check("frame_start1", busy[1], 1);
        for (int i = 0; i < delay; i++) begin
            if (dis_at >= 0) begin
                if (i == dis_at) begin
                    rx_enable   = 1'b0;
                    baud_select = 3'd0;
                end
                if (i == dis_at + 1) c0 = cycles;
                if (i == dis_at + 2) begin
                    check("held_div", cycles - c0, 27);
                    baud_select = 3'd7;
                end
            end
            wait_ticks(1);
        end
        Rx_DATA      = data;
        Rx_FERROR    = fe;
        Rx_PERROR    = pe;
        Rx_VALID     = !(fe | pe);
        clear_status = clr;
        rd_ready     = pop ? 2'b11 : 2'b00;
        for (int d = 0; d < 2; d++) model_event(d, {fe, pe, data}, pop, clr);
        step();
        clear_status = 1'b0;
        rd_ready     = 2'b00;
        for (int d = 0; d < 2; d++) check_dut(d);
        ticks = 0;
        cyc   = 0;
        while (busy[0] && cyc < 1000) begin
            if (Rx_sample[0]) ticks++;
            if (cyc == 2) begin
                {Rx_VALID, Rx_FERROR, Rx_PERROR} = 3'b000;
                Rx_DATA = 8'h00;
                RxD     = 1'b1;
            end
            step();
            cyc++;
        end
        check("drain_ticks", ticks, 16);
        check("en_after_drain", Rx_EN[0], rx_enable);
        check("busy1_after_drain", busy[1], 0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, ticks;
        logic [1:0] kind;
        reset = 1'b1; rx_enable = 1'b0; RxD = 1'b1; baud_select = 3'd7;
        {Rx_VALID, Rx_FERROR, Rx_PERROR} = 3'b000; Rx_DATA = 8'h00;
        rd_ready = 2'b00; clear_status = 1'b0;
        for (int d = 0; d < 2; d++) begin
            exp_ovf[d] = 1'b0;
            exp_err[d] = 0;
        end
        repeat (3) step();
        check_reset();

        reset = 1'b0;
        rx_enable = 1'b1;
        n = 0;
        while (!Rx_sample[0] && n < 100) begin step(); n++; end
        check("first_tick", n, 26);
        step(); n = 1;
        while (!Rx_sample[0] && n < 1000) begin step(); n++; end
        check("period_115200", n, 27);
        check("en_idle", Rx_EN[0], 1);

        baud_select = 3'd3;
        step(); n = 0;
        while (!Rx_sample[0] && n < 1000) begin step(); n++; end
        check("restart_9600", n, 325);
        step(); n = 1;
        while (!Rx_sample[0] && n < 1000) begin step(); n++; end
        check("period_9600", n, 326);
        baud_select = 3'd7;
        repeat (3) step();

        do_frame(8'hA5, 1'b0, 1'b0, 20, -1, 1'b0, 1'b0);
        pop_all();
        do_frame(8'h00, 1'b1, 1'b0, 15, -1, 1'b0, 1'b0);
        pop_all();

        do_frame(8'(($urandom)), 1'b0, 1'b0, 60, 50, 1'b0, 1'b0);
        check("off_after_defer", Rx_EN[0], 0);
        rx_enable = 1'b1;
        repeat (3) step();
        pop_all();

        for (int k = 0; k < 6; k++) begin
            kind = 2'($urandom_range(0, 3));
            do_frame(8'($urandom), kind[0], kind[1], $urandom_range(2, 20), -1, 1'b0,
                     1'($urandom_range(0, 1)));
            repeat (3) step();
        end
        pop_all();
        do_frame(8'($urandom), 1'b0, 1'b1, 5, -1, 1'b1, 1'b0);
        pop_all();

        clear_status = 1'b1;
        for (int d = 0; d < 2; d++) model_event(d, 10'd0, 1'b0, 1'b1);
        for (int d = 0; d < 2; d++) void'(mq[d].pop_back());
        step();
        clear_status = 1'b0;
        for (int d = 0; d < 2; d++) check_dut(d);
        for (int k = 0; k < 5; k++) begin
            do_frame(8'($urandom), 1'b0, 1'b0, $urandom_range(2, 12), -1, 1'b0, 1'b0);
            repeat (3) step();
        end
        do_frame(8'($urandom), 1'b0, 1'b0, 4, -1, 1'b0, 1'b1);
        pop_all();
        clear_status = 1'b1;
        step();
        clear_status = 1'b0;
        for (int d = 0; d < 2; d++) begin
            exp_ovf[d] = 1'b0;
            exp_err[d] = 0;
            check_dut(d);
        end

        RxD = 1'b0;
        repeat (3) step();
        RxD = 1'b1;
        n = 0;
        while (!busy[0] && n < 10) begin step(); n++; end
        check("glitch_start", busy[0], 1);
        ticks = 0; n = 0;
        while (busy[0] && n < 8000) begin
            if (Rx_sample[0]) ticks++;
            step();
            n++;
        end
        check("timeout_ticks", ticks, 208);
        for (int d = 0; d < 2; d++) check_dut(d);
        repeat (3) step();

        do_frame(8'h3C, 1'b0, 1'b1, 6, -1, 1'b0, 1'b0);
        repeat (3) step();
        RxD = 1'b0;
        n = 0;
        while (!busy[0] && n < 10) begin step(); n++; end
        wait_ticks(10);
        reset = 1'b1;
        RxD = 1'b1;
        step();
        for (int d = 0; d < 2; d++) begin
            mq[d].delete();
            exp_ovf[d] = 1'b0;
            exp_err[d] = 0;
        end
        check_reset();
        reset = 1'b0;
        repeat (4) step();
        do_frame(8'h5A, 1'b0, 1'b0, 8, -1, 1'b0, 1'b0);
        pop_all();

        check("no_en_drop", en_drops, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
